// File: rtl/rocc_cmd_dispatch.sv
// Two-unit RoCC command dispatcher: registers each core command, steers it to the unit chosen by
// funct[0] under a per-unit outstanding-response limit, and round-robin merges unit responses.
module rocc_cmd_dispatch #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_cmd_valid,
  output logic        io_cmd_ready,
  input  logic [6:0]  io_cmd_bits_inst_funct,
  input  logic [4:0]  io_cmd_bits_inst_rd,
  input  logic        io_cmd_bits_inst_xd,
  input  logic [63:0] io_cmd_bits_rs1,
  input  logic [63:0] io_cmd_bits_rs2,
  output logic        u0_cmd_valid,
  input  logic        u0_cmd_ready,
  output logic [6:0]  u0_cmd_bits_funct,
  output logic [4:0]  u0_cmd_bits_rd,
  output logic        u0_cmd_bits_xd,
  output logic [63:0] u0_cmd_bits_rs1,
  output logic [63:0] u0_cmd_bits_rs2,
  input  logic        u0_resp_valid,
  output logic        u0_resp_ready,
  input  logic [4:0]  u0_resp_bits_rd,
  input  logic [63:0] u0_resp_bits_data,
  output logic        u1_cmd_valid,
  input  logic        u1_cmd_ready,
  output logic [6:0]  u1_cmd_bits_funct,
  output logic [4:0]  u1_cmd_bits_rd,
  output logic        u1_cmd_bits_xd,
  output logic [63:0] u1_cmd_bits_rs1,
  output logic [63:0] u1_cmd_bits_rs2,
  input  logic        u1_resp_valid,
  output logic        u1_resp_ready,
  input  logic [4:0]  u1_resp_bits_rd,
  input  logic [63:0] u1_resp_bits_data,
  output logic        io_resp_valid,
  input  logic        io_resp_ready,
  output logic [4:0]  io_resp_bits_rd,
  output logic [63:0] io_resp_bits_data,
  output logic        io_busy,
  output logic        io_interrupt
);

  localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

  // Handshakes: a transfer happens on the rising edge where valid & ready are both high; once
  // raised, valid and its payload stay stable until that transfer. Ready may depend on valid.

  logic        hold_valid_q, hold_valid_d;
  logic [6:0]  hold_funct_q, hold_funct_d;
  logic [4:0]  hold_rd_q, hold_rd_d;
  logic        hold_xd_q, hold_xd_d;
  logic [63:0] hold_rs1_q, hold_rs1_d;
  logic [63:0] hold_rs2_q, hold_rs2_d;
  logic [2:0]  cnt_q [2];
  logic [2:0]  cnt_d [2];
  logic        rv_q, rv_d;
  logic [4:0]  resp_rd_q, resp_rd_d;
  logic [63:0] resp_data_q, resp_data_d;
  logic        rr_ptr_q, rr_ptr_d;

  logic       legal, sel, blocked, disp_valid, disp_fire, illegal_drop, hold_leaves, cmd_fire;
  logic       loadable;
  logic [1:0] resp_valid_vec, grant;

  assign legal        = (hold_funct_q[6:1] == 6'd0);
  assign sel          = hold_funct_q[0];
  assign blocked      = hold_xd_q && (cnt_q[sel] == MAX_CNT);
  assign disp_valid   = !reset && hold_valid_q && legal && !blocked;
  assign u0_cmd_valid = disp_valid && !sel;
  assign u1_cmd_valid = disp_valid && sel;
  assign disp_fire    = sel ? (u1_cmd_valid && u1_cmd_ready) : (u0_cmd_valid && u0_cmd_ready);
  // An illegal funct never reaches a unit; it is dropped one cycle after being held.
  assign illegal_drop = hold_valid_q && !legal;
  assign hold_leaves  = disp_fire || illegal_drop;
  assign io_cmd_ready = !reset && (!hold_valid_q || hold_leaves);
  assign cmd_fire     = io_cmd_valid && io_cmd_ready;
  assign io_interrupt = !reset && illegal_drop;

  assign u0_cmd_bits_funct = hold_funct_q;
  assign u0_cmd_bits_rd    = hold_rd_q;
  assign u0_cmd_bits_xd    = hold_xd_q;
  assign u0_cmd_bits_rs1   = hold_rs1_q;
  assign u0_cmd_bits_rs2   = hold_rs2_q;
  assign u1_cmd_bits_funct = hold_funct_q;
  assign u1_cmd_bits_rd    = hold_rd_q;
  assign u1_cmd_bits_xd    = hold_xd_q;
  assign u1_cmd_bits_rs1   = hold_rs1_q;
  assign u1_cmd_bits_rs2   = hold_rs2_q;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_funct_d = hold_funct_q;
    hold_rd_d    = hold_rd_q;
    hold_xd_d    = hold_xd_q;
    hold_rs1_d   = hold_rs1_q;
    hold_rs2_d   = hold_rs2_q;
    if (cmd_fire) begin
      hold_valid_d = 1'b1;
      hold_funct_d = io_cmd_bits_inst_funct;
      hold_rd_d    = io_cmd_bits_inst_rd;
      hold_xd_d    = io_cmd_bits_inst_xd;
      hold_rs1_d   = io_cmd_bits_rs1;
      hold_rs2_d   = io_cmd_bits_rs2;
    end else if (hold_leaves) begin
      hold_valid_d = 1'b0;
    end
  end

  // Response arbiter: the unit named by rr_ptr wins when valid, otherwise the other one.
  assign resp_valid_vec = {u1_resp_valid, u0_resp_valid};
  assign loadable       = !reset && (!rv_q || io_resp_ready);

  always_comb begin
    grant = 2'b00;
    if (loadable) begin
      if (resp_valid_vec[rr_ptr_q]) begin
        grant[rr_ptr_q] = 1'b1;
      end else if (resp_valid_vec[~rr_ptr_q]) begin
        grant[~rr_ptr_q] = 1'b1;
      end
    end
  end

  assign u0_resp_ready = grant[0];
  assign u1_resp_ready = grant[1];

  always_comb begin
    rv_d        = rv_q;
    resp_rd_d   = resp_rd_q;
    resp_data_d = resp_data_q;
    rr_ptr_d    = rr_ptr_q;
    if (grant != 2'b00) begin
      rv_d        = 1'b1;
      resp_rd_d   = grant[1] ? u1_resp_bits_rd : u0_resp_bits_rd;
      resp_data_d = grant[1] ? u1_resp_bits_data : u0_resp_bits_data;
      rr_ptr_d    = ~grant[1];
    end else if (io_resp_ready) begin
      rv_d = 1'b0;
    end
  end

  // Outstanding counters: a simultaneous dispatch and response cancel; decrement stops at zero.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      cnt_d[n] = cnt_q[n];
      if (disp_fire && hold_xd_q && (sel == 1'(n)) && !grant[n]) begin
        cnt_d[n] = cnt_q[n] + 3'd1;
      end else if (grant[n] && !(disp_fire && hold_xd_q && (sel == 1'(n))) && (cnt_q[n] != 3'd0)) begin
        cnt_d[n] = cnt_q[n] - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      hold_funct_q <= '0;
      hold_rd_q    <= '0;
      hold_xd_q    <= 1'b0;
      hold_rs1_q   <= '0;
      hold_rs2_q   <= '0;
      cnt_q[0]     <= '0;
      cnt_q[1]     <= '0;
      rv_q         <= 1'b0;
      resp_rd_q    <= '0;
      resp_data_q  <= '0;
      rr_ptr_q     <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_funct_q <= hold_funct_d;
      hold_rd_q    <= hold_rd_d;
      hold_xd_q    <= hold_xd_d;
      hold_rs1_q   <= hold_rs1_d;
      hold_rs2_q   <= hold_rs2_d;
      cnt_q[0]     <= cnt_d[0];
      cnt_q[1]     <= cnt_d[1];
      rv_q         <= rv_d;
      resp_rd_q    <= resp_rd_d;
      resp_data_q  <= resp_data_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  assign io_resp_valid     = rv_q;
  assign io_resp_bits_rd   = resp_rd_q;
  assign io_resp_bits_data = resp_data_q;
  assign io_busy           = hold_valid_q || rv_q || (cnt_q[0] != 3'd0) || (cnt_q[1] != 3'd0);

endmodule

// File: tb/tb_rocc_cmd_dispatch.sv
// Bench for rocc_cmd_dispatch: scenario tasks drive the core and both units; a negedge monitor
// scoreboards dispatched commands and merged responses against queues filled from the stimulus.
module tb_rocc_cmd_dispatch;

  localparam int CW = 142;
  localparam int RW = 69;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [6:0]  funct = '0;
  logic [4:0]  rd = '0;
  logic        xd = 1'b0;
  logic [63:0] rs1 = '0, rs2 = '0;
  logic        u0_cmd_ready = 1'b0, u1_cmd_ready = 1'b0;
  logic        u0_resp_valid = 1'b0, u1_resp_valid = 1'b0;
  logic [4:0]  u0_resp_rd = '0, u1_resp_rd = '0;
  logic [63:0] u0_resp_data = '0, u1_resp_data = '0;
  logic        resp_ready = 1'b0;

  logic        io_cmd_ready, io_resp_valid, io_busy, io_interrupt;
  logic [4:0]  io_resp_bits_rd;
  logic [63:0] io_resp_bits_data;
  logic        u0_cmd_valid, u1_cmd_valid, u0_resp_ready, u1_resp_ready;
  logic [6:0]  u0_cmd_bits_funct, u1_cmd_bits_funct;
  logic [4:0]  u0_cmd_bits_rd, u1_cmd_bits_rd;
  logic        u0_cmd_bits_xd, u1_cmd_bits_xd;
  logic [63:0] u0_cmd_bits_rs1, u0_cmd_bits_rs2, u1_cmd_bits_rs1, u1_cmd_bits_rs2;

  logic [CW-1:0] cmd_q[$];
  logic [RW-1:0] exp_q[$];
  logic [CW-1:0] mon_cact, mon_cexp;
  logic [RW-1:0] mon_ract, mon_rexp;
  int tests_run = 0;
  int tests_failed = 0;
  int disp0 = 0;
  int disp1 = 0;

  rocc_cmd_dispatch #(.MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset),
    .io_cmd_valid(cmd_valid), .io_cmd_ready(io_cmd_ready),
    .io_cmd_bits_inst_funct(funct), .io_cmd_bits_inst_rd(rd), .io_cmd_bits_inst_xd(xd),
    .io_cmd_bits_rs1(rs1), .io_cmd_bits_rs2(rs2),
    .u0_cmd_valid(u0_cmd_valid), .u0_cmd_ready(u0_cmd_ready),
    .u0_cmd_bits_funct(u0_cmd_bits_funct), .u0_cmd_bits_rd(u0_cmd_bits_rd),
    .u0_cmd_bits_xd(u0_cmd_bits_xd), .u0_cmd_bits_rs1(u0_cmd_bits_rs1),
    .u0_cmd_bits_rs2(u0_cmd_bits_rs2),
    .u0_resp_valid(u0_resp_valid), .u0_resp_ready(u0_resp_ready),
    .u0_resp_bits_rd(u0_resp_rd), .u0_resp_bits_data(u0_resp_data),
    .u1_cmd_valid(u1_cmd_valid), .u1_cmd_ready(u1_cmd_ready),
    .u1_cmd_bits_funct(u1_cmd_bits_funct), .u1_cmd_bits_rd(u1_cmd_bits_rd),
    .u1_cmd_bits_xd(u1_cmd_bits_xd), .u1_cmd_bits_rs1(u1_cmd_bits_rs1),
    .u1_cmd_bits_rs2(u1_cmd_bits_rs2),
    .u1_resp_valid(u1_resp_valid), .u1_resp_ready(u1_resp_ready),
    .u1_resp_bits_rd(u1_resp_rd), .u1_resp_bits_data(u1_resp_data),
    .io_resp_valid(io_resp_valid), .io_resp_ready(resp_ready),
    .io_resp_bits_rd(io_resp_bits_rd), .io_resp_bits_data(io_resp_bits_data),
    .io_busy(io_busy), .io_interrupt(io_interrupt)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0; u0_cmd_ready = 1'b0; u1_cmd_ready = 1'b0;
    u0_resp_valid = 1'b0; u1_resp_valid = 1'b0; resp_ready = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // Scoreboard monitor: pops on unit dispatch / core response, pushes on accepted legal command
  always @(negedge clk) begin
    if (u0_cmd_valid && u0_cmd_ready) begin
      disp0++;
      tests_run++;
      mon_cact = {1'b0, u0_cmd_bits_funct, u0_cmd_bits_rd, u0_cmd_bits_xd, u0_cmd_bits_rs1, u0_cmd_bits_rs2};
      if (cmd_q.size() == 0) begin
        tests_failed++;
        $display("FAIL dispatch_u0: got unexpected %h, expected no dispatch", mon_cact);
      end else begin
        mon_cexp = cmd_q.pop_front();
        if (mon_cact !== mon_cexp) begin
          tests_failed++;
          $display("FAIL dispatch_u0: got %h expected %h", mon_cact, mon_cexp);
        end
      end
    end
    if (u1_cmd_valid && u1_cmd_ready) begin
      disp1++;
      tests_run++;
      mon_cact = {1'b1, u1_cmd_bits_funct, u1_cmd_bits_rd, u1_cmd_bits_xd, u1_cmd_bits_rs1, u1_cmd_bits_rs2};
      if (cmd_q.size() == 0) begin
        tests_failed++;
        $display("FAIL dispatch_u1: got unexpected %h, expected no dispatch", mon_cact);
      end else begin
        mon_cexp = cmd_q.pop_front();
        if (mon_cact !== mon_cexp) begin
          tests_failed++;
          $display("FAIL dispatch_u1: got %h expected %h", mon_cact, mon_cexp);
        end
      end
    end
    if (io_resp_valid && resp_ready) begin
      tests_run++;
      mon_ract = {io_resp_bits_rd, io_resp_bits_data};
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL io_resp: got unexpected %h, expected no response", mon_ract);
      end else begin
        mon_rexp = exp_q.pop_front();
        if (mon_ract !== mon_rexp) begin
          tests_failed++;
          $display("FAIL io_resp: got %h expected %h", mon_ract, mon_rexp);
        end
      end
    end
    if (cmd_valid && io_cmd_ready && (funct[6:1] == 6'd0))
      cmd_q.push_back({funct[0], funct, rd, xd, rs1, rs2});
  end

  task automatic test_reset();
    cyc();
    #1;
    tests_run++;
    if (io_cmd_ready !== 1'b0) begin
      tests_failed++; $display("FAIL reset_cmd_ready_in_reset: got %b expected 0", io_cmd_ready);
    end
    cyc();
    reset = 1'b0;
    #1;
    tests_run++;
    if (io_cmd_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_cmd_ready_after: got %b expected 1", io_cmd_ready);
    end
    tests_run++;
    if ({u0_cmd_valid, u1_cmd_valid, u0_resp_ready, u1_resp_ready, io_resp_valid, io_busy, io_interrupt} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {u0_cmd_valid, u1_cmd_valid, u0_resp_ready, u1_resp_ready, io_resp_valid, io_busy, io_interrupt});
    end
    tests_run++;
    if ({io_resp_bits_rd, io_resp_bits_data} !== 69'd0) begin
      tests_failed++; $display("FAIL reset_resp_bits: got %h expected 0", {io_resp_bits_rd, io_resp_bits_data});
    end
  endtask

  task automatic test_basic();
    cyc();
    cmd_valid = 1'b1; funct = 7'd0; xd = 1'b1; rs1 = 64'd5; rs2 = 64'd7; rd = 5'd3; u0_cmd_ready = 1'b1;
    #1;
    tests_run++;
    if (io_cmd_ready !== 1'b1) begin
      tests_failed++; $display("FAIL basic_cmd_ready: got %b expected 1", io_cmd_ready);
    end
    cyc();
    cmd_valid = 1'b0;
    #1;
    tests_run++;
    if ({u1_cmd_valid, u0_cmd_valid} !== 2'b01) begin
      tests_failed++; $display("FAIL basic_cmd_valid: got %b expected 01", {u1_cmd_valid, u0_cmd_valid});
    end
    tests_run++;
    if ({u0_cmd_bits_rs1, u0_cmd_bits_rs2} !== {64'd5, 64'd7}) begin
      tests_failed++; $display("FAIL basic_operands: got %0d/%0d expected 5/7", u0_cmd_bits_rs1, u0_cmd_bits_rs2);
    end
    cyc();
    u0_resp_valid = 1'b1; u0_resp_rd = 5'd3; u0_resp_data = 64'd12; resp_ready = 1'b1;
    exp_q.push_back({5'd3, 64'd12});
    #1;
    tests_run++;
    if ({u0_resp_ready, io_busy} !== 2'b11) begin
      tests_failed++; $display("FAIL basic_resp_ready_busy: got %b expected 11", {u0_resp_ready, io_busy});
    end
    cyc();
    u0_resp_valid = 1'b0;
    #1;
    tests_run++;
    if (io_resp_valid !== 1'b1) begin
      tests_failed++; $display("FAIL basic_resp_latency: got %b expected 1", io_resp_valid);
    end
    cyc();
    #1;
    tests_run++;
    if ({io_busy, io_resp_valid} !== 2'b00) begin
      tests_failed++; $display("FAIL basic_idle: got %b expected 00", {io_busy, io_resp_valid});
    end
  endtask

  task automatic test_outstanding();
    int   sent;
    int   d0;
    logic acc;
    sent = 0; acc = 1'b0; d0 = disp1;
    u0_cmd_ready = 1'b0; u1_cmd_ready = 1'b1; resp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (acc) sent++;
      u1_resp_valid = (i == 10);
      if (i == 10) begin
        u1_resp_rd = 5'd9; u1_resp_data = 64'h99;
        exp_q.push_back({5'd9, 64'h99});
      end
      cmd_valid = (sent < 4); funct = 7'd1; xd = 1'b1; rd = 5'(sent + 1);
      rs1 = 64'(100 + sent); rs2 = 64'(200 + $urandom_range(0, 50));
      #1;
      acc = cmd_valid && io_cmd_ready;
      if (i == 9) begin
        tests_run++;
        if ((disp1 - d0) !== 2 || sent !== 3) begin
          tests_failed++; $display("FAIL limit_dispatches: got %0d disp/%0d sent expected 2/3", disp1 - d0, sent);
        end
        tests_run++;
        if ({u1_cmd_valid, io_cmd_ready, io_busy} !== 3'b001) begin
          tests_failed++; $display("FAIL limit_stall: got %b expected 001", {u1_cmd_valid, io_cmd_ready, io_busy});
        end
      end
    end
    tests_run++;
    if ((disp1 - d0) !== 3 || sent !== 4 || u1_cmd_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL limit_release: got %0d disp/%0d sent/valid %b expected 3/4/0", disp1 - d0, sent, u1_cmd_valid);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      u1_resp_valid = 1'b1;
      exp_q.push_back({5'd9, 64'h99});
    end
    cyc();
    u1_resp_valid = 1'b0;
    cyc();
    #1;
    tests_run++;
    if ((disp1 - d0) !== 4 || io_busy !== 1'b0) begin
      tests_failed++; $display("FAIL limit_drain: got %0d disp/busy %b expected 4/0", disp1 - d0, io_busy);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    u0_resp_valid = 1'b1; u0_resp_rd = 5'd1; u0_resp_data = 64'hA;
    u1_resp_valid = 1'b1; u1_resp_rd = 5'd2; u1_resp_data = 64'hB;
    resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      tests_run++;
      if ({u1_resp_ready, u0_resp_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        tests_failed++; $display("FAIL rr_grant_%0d: got %b", i, {u1_resp_ready, u0_resp_ready});
      end
      if (i % 2 == 0) exp_q.push_back({5'd1, 64'hA});
      else exp_q.push_back({5'd2, 64'hB});
      cyc();
    end
    resp_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      tests_run++;
      if ({u1_resp_ready, u0_resp_ready, io_resp_valid} !== 3'b001 ||
          {io_resp_bits_rd, io_resp_bits_data} !== {5'd2, 64'hB}) begin
        tests_failed++;
        $display("FAIL rr_stall_%0d: got rdy %b valid %b data %h expected 00/1/B", j,
                 {u1_resp_ready, u0_resp_ready}, io_resp_valid, io_resp_bits_data);
      end
      cyc();
    end
    resp_ready = 1'b1; u0_resp_valid = 1'b0; u1_resp_valid = 1'b0;
    cyc();
    #1;
    tests_run++;
    if (io_resp_valid !== 1'b0) begin
      tests_failed++; $display("FAIL rr_drain: got %b expected 0", io_resp_valid);
    end
  endtask

  task automatic test_illegal();
    int d;
    d = disp0 + disp1;
    u0_cmd_ready = 1'b1; u1_cmd_ready = 1'b1;
    cmd_valid = 1'b1; funct = 7'h04; xd = 1'b1; rd = 5'd5; rs1 = 64'd1; rs2 = 64'd2;
    #1;
    tests_run++;
    if ({io_cmd_ready, io_interrupt} !== 2'b10) begin
      tests_failed++; $display("FAIL illegal_accept: got %b expected 10", {io_cmd_ready, io_interrupt});
    end
    cyc();
    cmd_valid = 1'b0;
    #1;
    tests_run++;
    if ({io_interrupt, u1_cmd_valid, u0_cmd_valid, io_cmd_ready} !== 4'b1001) begin
      tests_failed++;
      $display("FAIL illegal_pulse: got %b expected 1001", {io_interrupt, u1_cmd_valid, u0_cmd_valid, io_cmd_ready});
    end
    cyc();
    #1;
    tests_run++;
    if ({io_interrupt, io_busy, io_resp_valid} !== 3'b000 || (disp0 + disp1) !== d) begin
      tests_failed++;
      $display("FAIL illegal_after: got %b disp %0d expected 000 disp %0d",
               {io_interrupt, io_busy, io_resp_valid}, disp0 + disp1, d);
    end
  endtask

  task automatic test_same_cycle();
    u0_cmd_ready = 1'b1; resp_ready = 1'b1;
    cmd_valid = 1'b1; funct = 7'd0; xd = 1'b1; rd = 5'd4; rs1 = 64'd10; rs2 = 64'd11;
    cyc();
    cmd_valid = 1'b0;
    cyc();
    cmd_valid = 1'b1; xd = 1'b1; rd = 5'd6; rs1 = 64'd20;
    cyc();
    cmd_valid = 1'b1; xd = 1'b0; rd = 5'd7; rs1 = 64'd30;
    u0_resp_valid = 1'b1; u0_resp_rd = 5'd4; u0_resp_data = 64'd21;
    exp_q.push_back({5'd4, 64'd21});
    #1;
    tests_run++;
    if ({u0_cmd_valid, u0_resp_ready} !== 2'b11) begin
      tests_failed++; $display("FAIL same_cycle_fire: got %b expected 11", {u0_cmd_valid, u0_resp_ready});
    end
    cyc();
    cmd_valid = 1'b0; u0_resp_valid = 1'b0;
    #1;
    tests_run++;
    if ({u0_cmd_valid, u0_cmd_bits_xd} !== 2'b10) begin
      tests_failed++; $display("FAIL same_cycle_xd0: got %b expected 10", {u0_cmd_valid, u0_cmd_bits_xd});
    end
    cyc();
    #1;
    tests_run++;
    if (io_busy !== 1'b1) begin
      tests_failed++; $display("FAIL same_cycle_cnt_one: got busy %b expected 1", io_busy);
    end
    u0_resp_valid = 1'b1; u0_resp_rd = 5'd6; u0_resp_data = 64'd22;
    exp_q.push_back({5'd6, 64'd22});
    cyc();
    u0_resp_valid = 1'b0;
    cyc();
    #1;
    tests_run++;
    if (io_busy !== 1'b0) begin
      tests_failed++; $display("FAIL same_cycle_cnt_zero: got busy %b expected 0", io_busy);
    end
  endtask

  task automatic test_reset_mid();
    u0_cmd_ready = 1'b1; u1_cmd_ready = 1'b1; resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; funct = 7'd0; xd = 1'b1; rd = 5'(i); rs1 = 64'(40 + i); rs2 = 64'($urandom_range(0, 999));
      cyc();
    end
    cmd_valid = 1'b0;
    u1_resp_valid = 1'b1; u1_resp_rd = 5'd1; u1_resp_data = 64'h55;
    #1;
    tests_run++;
    if ({u0_cmd_valid, io_cmd_ready, u1_resp_ready} !== 3'b001) begin
      tests_failed++; $display("FAIL mid_full: got %b expected 001", {u0_cmd_valid, io_cmd_ready, u1_resp_ready});
    end
    cyc();
    u1_resp_valid = 1'b0;
    #1;
    tests_run++;
    if ({io_resp_valid, io_busy} !== 2'b11) begin
      tests_failed++; $display("FAIL mid_pending: got %b expected 11", {io_resp_valid, io_busy});
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    cmd_q.delete();
    tests_run++;
    if ({io_cmd_ready, u0_cmd_valid, u1_cmd_valid, io_resp_valid, io_busy, io_interrupt} !== 6'b100000 ||
        {io_resp_bits_rd, io_resp_bits_data} !== 69'd0) begin
      tests_failed++;
      $display("FAIL mid_reset_values: got %b bits %h expected 100000 bits 0",
               {io_cmd_ready, u0_cmd_valid, u1_cmd_valid, io_resp_valid, io_busy, io_interrupt},
               {io_resp_bits_rd, io_resp_bits_data});
    end
    cmd_valid = 1'b1; funct = 7'd1; xd = 1'b0; rd = 5'd11; rs1 = 64'd77; rs2 = 64'd88;
    cyc();
    cmd_valid = 1'b0;
    #1;
    tests_run++;
    if ({u1_cmd_valid, u0_cmd_valid} !== 2'b10) begin
      tests_failed++; $display("FAIL mid_fresh_dispatch: got %b expected 10", {u1_cmd_valid, u0_cmd_valid});
    end
    cyc();
    #1;
    tests_run++;
    if (io_busy !== 1'b0) begin
      tests_failed++; $display("FAIL mid_fresh_idle: got %b expected 0", io_busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_outstanding();
    test_round_robin();
    test_illegal();
    test_same_cycle();
    test_reset_mid();
    cyc();
    tests_run++;
    if (exp_q.size() !== 0 || cmd_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL leftover: got %0d resp/%0d cmd expected 0/0", exp_q.size(), cmd_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rocc_cmd_dispatch.md
# rocc_cmd_dispatch

Two-unit RoCC command dispatcher and response arbiter placed between the core's RoCC command/response ports and two single-command accelerator units, e.g. adder-style units. It registers each incoming command and steers it to a unit selected by `funct`. It limits outstanding responses per unit and merges the units' responses back into the single RoCC response port with round-robin fairness. It also drives `io_busy` and flags illegal `funct` codes on `io_interrupt`.

## Interface
- MAX_OUTSTANDING, 2: maximum in-flight responding commands (xd=1) per unit, 1..7
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- io_cmd_valid / io_cmd_ready  in / out  1 / 1  core command handshake
- io_cmd_bits_inst_funct  in  7  bit0 = unit select; bits[6:1] must be 0
- io_cmd_bits_inst_rd  in  5  destination register
- io_cmd_bits_inst_xd  in  1  command expects a response
- io_cmd_bits_rs1, io_cmd_bits_rs2  in  64 each  operands
- uN_cmd_valid / uN_cmd_ready  out / in  1 / 1  unit N command handshake (N = 0,1)
- uN_cmd_bits_funct, _rd, _xd, _rs1, _rs2  out  7,5,1,64,64  held command fields, shared by both units
- uN_resp_valid / uN_resp_ready  in / out  1 / 1  unit N response handshake
- uN_resp_bits_rd, uN_resp_bits_data  in  5 / 64  unit N response payload
- io_resp_valid / io_resp_ready  out / in  1 / 1  merged response to core
- io_resp_bits_rd, io_resp_bits_data  out  5 / 64  registered response payload
- io_busy  out  1  command held or any response outstanding/pending
- io_interrupt  out  1  one-cycle pulse on illegal funct

## Operation
- Hold register (valid, funct, rd, xd, rs1, rs2) is loaded on io_cmd_valid & io_cmd_ready.
- io_cmd_ready = !reset & (!hold_valid | hold_leaves), where hold_leaves = dispatch fire or illegal drop this cycle.
- sel = hold_funct[0]. Only u<sel>_cmd_valid = hold_valid & legal & !(hold_xd & cnt[sel]==MAX_OUTSTANDING). The other unit's valid is 0.
- Dispatch fires on u<sel>_cmd_valid & u<sel>_cmd_ready. Hold frees or reloads the same edge.
- Illegal (hold_funct[6:1]≠0): hold dropped the cycle after load, no unit sees it, no response generated. io_interrupt = 1 for exactly that cycle.
- cnt[N] (3 bits): +1 on dispatch to N with xd=1; −1 on uN_resp fire. Both in the same cycle leaves it unchanged.
- A unit response arriving while cnt[N]==0 is still accepted. cnt saturates at 0; this is a protocol error, not detected.
- Response register (rv, rd, data) is loadable when !rv | io_resp_ready.
- When loadable, the arbiter grants one valid unit: the one matching rr_ptr if it is valid, else the other. uN_resp_ready = loadable & grant[N].
- On grant, rv<=1, payload captured, rr_ptr <= ~granted unit.
- rv clears on io_resp_ready with no new grant.
- io_busy = hold_valid | rv | cnt[0]≠0 | cnt[1]≠0.
- Reset (any time, including mid-operation): hold_valid=0, rv=0, cnt=0, rr_ptr=0. In-flight responses are discarded and not replayed.

## Timing
- Reset values: io_cmd_ready=0 while reset high, 1 the cycle after. All uN_cmd_valid, uN_resp_ready, io_resp_valid, io_busy, io_interrupt = 0. io_resp_bits_* = 0.
- Command latency: accept at cycle T, uN_cmd_valid high at T+1. Back-to-back accept is possible if the unit is ready (1 command/cycle).
- Response latency: unit fire at cycle T, io_resp_valid high at T+1. Full throughput of 1 response/cycle when io_resp_ready stays high.
- Hold and response stages are independent. Dispatch and response acceptance may occur in the same cycle.
- io_resp_* and uN_cmd_bits_* are stable while their valid is high and not yet accepted.

## Test plan
- Reset then funct=0, xd=1, rs1=5, rs2=7, rd=3, u0 ready: u0_cmd_valid at T+1 with rs1=5/rs2=7; u1 idle. u0 responds rd=3 data=12 → io_resp rd=3 data=12 one cycle later, io_busy drops after the core accepts.
- funct=1 stream of 4 xd=1 commands, u1 ready but never responding: exactly MAX_OUTSTANDING=2 dispatches, then u1_cmd_valid=0 and io_cmd_ready=0 with the hold full. One u1 response releases exactly one more dispatch.
- Both units hold resp_valid continuously (u0 data=0xA, u1 data=0xB), io_resp_ready=1: output sequence A,B,A,B…. Drop io_resp_ready for 3 cycles: io_resp held stable, no uN_resp_ready.
- funct=0x04, xd=1: no uN_cmd_valid, io_interrupt pulses exactly 1 cycle, no response, cnt unchanged.
- Same-cycle u0 dispatch (xd=1) and u0 response fire with cnt[0]=1: cnt[0] stays 1. Then xd=0 dispatch: cnt[0] unchanged.
- Assert reset with a hold entry, rv=1 and cnt=2: the next cycle all outputs are at reset values, and a fresh command dispatches normally.
